// File: rtl/armleocpu_ptw.sv
// Sv32 page table walker: resolves a 20-bit VPN into a 22-bit PPN plus access tag
// using up to two PTE reads over a single-outstanding memory port.
module armleocpu_ptw (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        resolve_request,
    input  logic [19:0] virtual_address,
    input  logic [21:0] satp_ppn,
    output logic        resolve_done,
    output logic        resolve_pagefault,
    output logic        resolve_accessfault,
    output logic [21:0] resolve_physical_address,
    output logic [7:0]  resolve_accesstag,
    output logic        mem_read,
    output logic [33:0] mem_address,
    input  logic        mem_done,
    input  logic        mem_error,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

    state_e      state_q, state_d;
    logic        level_q, level_d;
    logic [19:0] vpn_q, vpn_d;
    logic [21:0] table_q, table_d;
    logic [21:0] phys_q, phys_d;
    logic [7:0]  tag_q, tag_d;
    logic        pf_q, pf_d;
    logic        af_q, af_d;

    logic [9:0]  vpn_level;
    logic        pte_valid, pte_r, pte_w, pte_x;
    logic        unused_rsw;

    assign pte_valid  = mem_readdata[0];
    assign pte_r      = mem_readdata[1];
    assign pte_w      = mem_readdata[2];
    assign pte_x      = mem_readdata[3];
    assign unused_rsw = ^mem_readdata[9:8];

    assign vpn_level = level_q ? vpn_q[19:10] : vpn_q[9:0];

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        vpn_d   = vpn_q;
        table_d = table_q;
        phys_d  = phys_q;
        tag_d   = tag_q;
        pf_d    = pf_q;
        af_d    = af_q;
        unique case (state_q)
            StIdle: begin
                if (resolve_request) begin
                    vpn_d   = virtual_address;
                    table_d = satp_ppn;
                    level_d = 1'b1;
                    phys_d  = '0;
                    tag_d   = '0;
                    pf_d    = 1'b0;
                    af_d    = 1'b0;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (mem_done) begin
                    state_d = StDone;
                    if (mem_error) begin
                        af_d = 1'b1;
                    end else if (!pte_valid || (!pte_r && pte_w)) begin
                        pf_d = 1'b1;
                    end else if (pte_r || pte_x) begin
                        if (level_q) begin
                            // Megapage PPN[0] must be zero; low PPN comes from the VA
                            if (mem_readdata[19:10] != 10'd0) begin
                                pf_d = 1'b1;
                            end else begin
                                phys_d = {mem_readdata[31:20], vpn_q[9:0]};
                                tag_d  = mem_readdata[7:0];
                            end
                        end else begin
                            phys_d = mem_readdata[31:10];
                            tag_d  = mem_readdata[7:0];
                        end
                    end else if (level_q) begin
                        table_d = mem_readdata[31:10];
                        level_d = 1'b0;
                        state_d = StRead;
                    end else begin
                        pf_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            level_q <= 1'b0;
            vpn_q   <= '0;
            table_q <= '0;
            phys_q  <= '0;
            tag_q   <= '0;
            pf_q    <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            vpn_q   <= vpn_d;
            table_q <= table_d;
            phys_q  <= phys_d;
            tag_q   <= tag_d;
            pf_q    <= pf_d;
            af_q    <= af_d;
        end
    end

    assign mem_read    = (state_q == StRead);
    assign mem_address = mem_read ? ({table_q, 12'h000} + {22'd0, vpn_level, 2'b00}) : 34'd0;

    assign resolve_done             = (state_q == StDone);
    assign resolve_pagefault        = pf_q;
    assign resolve_accessfault      = af_q;
    assign resolve_physical_address = phys_q;
    assign resolve_accesstag        = tag_q;

endmodule

// File: doc/armleocpu_ptw.md
# armleocpu_ptw

Sv32 hardware page table walker that fills the TLB. On a TLB miss the fetch/data unit issues a resolve request with the 20-bit virtual page number. The walker performs up to two page table reads over a single-outstanding memory port. It returns the 22-bit physical page number plus the 8-bit access tag, in exactly the `phys_w`/`accesstag_w` format the TLB write port consumes, or it reports a page fault or an access fault.

## Interface
- No parameters; Sv32 widths are fixed.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `resolve_request`  in  1  start a walk; sampled only in IDLE.
- `virtual_address`  in  20  VPN {vpn1[19:10], vpn0[9:0]}; latched on accept.
- `satp_ppn`  in  22  root page table PPN; latched on accept.
- `resolve_done`  out  1  one-cycle pulse; result outputs are valid this cycle.
- `resolve_pagefault`  out  1  walk ended in a page fault; valid with `resolve_done`.
- `resolve_accessfault`  out  1  memory returned an error; valid with `resolve_done`.
- `resolve_physical_address`  out  22  resulting PPN.
- `resolve_accesstag`  out  8  leaf PTE[7:0] (D A G U X W R V).
- `mem_read`  out  1  read request; held high until `mem_done`.
- `mem_address`  out  34  physical byte address of the PTE; stable while `mem_read` is high.
- `mem_done`  in  1  read complete.
- `mem_error`  in  1  access error; qualified by `mem_done`.
- `mem_readdata`  in  32  PTE; qualified by `mem_done`.

## Operation
- States: IDLE, READ, DONE.
- IDLE:
  - If `resolve_request` is high, latch `virtual_address` and `satp_ppn`, set level=1 and table=`satp_ppn`, then go to READ.
  - Otherwise stay in IDLE.
- READ:
  - `mem_read`=1.
  - `mem_address` = {table, 12'b0} + {vpn_level, 2'b00}, computed in 34 bits with no truncation. vpn_level is vpn1 at level 1 and vpn0 at level 0.
  - Stay in READ while `mem_done`=0.
- PTE evaluation, on the cycle `mem_done`=1 (first matching rule wins):
  - `mem_error`=1: access fault → DONE.
  - V=0, or (R=0 and W=1): page fault → DONE.
  - Leaf (R or X set) at level 1:
    - If PTE[19:10] ≠ 0 (misaligned megapage): page fault → DONE.
    - Otherwise phys = {PTE[31:20], vpn0}, tag = PTE[7:0] → DONE.
  - Leaf at level 0: phys = PTE[31:10], tag = PTE[7:0] → DONE.
  - Non-leaf at level 1: table = PTE[31:10], level = 0, stay in READ. `mem_read` remains high and the new address appears the next cycle.
  - Non-leaf at level 0: page fault → DONE.
- DONE:
  - `resolve_done`=1 for exactly one cycle, then go to IDLE.
  - Fault flags are mutually exclusive.
  - On any fault, phys and tag are driven to 0.
- `resolve_request` outside IDLE is ignored; it is not queued.
- A/D bits are not updated and permissions are not checked; both are the TLB user's responsibility.

## Timing
- Reset values: state IDLE; `mem_read`, `resolve_done`, `resolve_pagefault`, `resolve_accessfault` all 0; `mem_address`, `resolve_physical_address`, `resolve_accesstag` all 0.
- Latency: request accepted at edge N → `mem_read` high in cycle N+1.
- Each read costs its memory latency L (≥1 cycle, `mem_done` in the L-th cycle of `mem_read`), plus one cycle from final `mem_done` to `resolve_done`.
  - Two-level walk with L=1: `resolve_done` at cycle N+3.
  - Megapage walk with L=1: `resolve_done` at cycle N+2.
- Result outputs are registered and hold their value until the next accept.
- Changes to `virtual_address`/`satp_ppn` after accept have no effect on the walk in progress.
- `rst_n` low mid-walk: immediately IDLE, `mem_read`=0, no `resolve_done`. A `mem_done` arriving later in IDLE is ignored.
- A new request asserted in the DONE cycle is not accepted; it is accepted on the following IDLE cycle.

## Test plan
- Two-level hit: `satp_ppn`=22'h00001, VA=20'h2_0001.
  - Expect `mem_address`=34'h1200; return 32'h0000_0801.
  - Expect `mem_address`=34'h2004; return 32'h0400_04B3.
  - Expect `resolve_done`, phys=22'h1_0001, tag=8'hB3, no faults.
- Megapage: same VA; level-1 PTE 32'h0010_00CF → single read, phys=22'h00_0401, tag=8'hCF.
- Megapage misaligned: level-1 PTE 32'h0000_04CF → `resolve_pagefault`=1, phys=0, tag=0.
- Invalid/illegal PTEs each → page fault:
  - level-1 PTE 32'h0;
  - PTE with W=1, R=0 (32'h0000_0005);
  - non-leaf 32'h0000_0801 returned at level 0.
- Memory error: `mem_done`=1 with `mem_error`=1 on the first read → `resolve_accessfault`=1, pagefault=0, one pulse.
- Robustness, each checked on its own:
  - `mem_done` delayed 5 cycles: `mem_address` stays stable.
  - `resolve_request` held through a walk: exactly one walk per IDLE acceptance.
  - `rst_n` pulsed low during READ: `mem_read` drops asynchronously and no `resolve_done` follows.
